// File: rtl/seg7_bus_decoder.sv
// Passive monitor for a multiplexed active-low 7-segment bus. Recovers the BCD
// value of each digit after a stable dwell and flags framing and pattern errors.
module seg7_bus_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_stb,
  output logic                    err_pattern,
  output logic                    err_anode
);

  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int LW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_TRIG = CW'(STABLE_CYCLES - 1);

  logic [SW-1:0]         sample;
  logic [SW-1:0]         s_q;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic                  same;
  logic                  dwell;
  logic [LW-1:0]         low_cnt;
  logic                  capture;
  logic                  multi;
  logic [NUM_DIGITS-1:0] sel_mask;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_upd;
  logic                  frame_done;
  logic [4:0]            dec;
  logic                  pattern_bad;

  // Returns {legal, value}; blank reads back as a legal 4'hF.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      7'b1111111: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  assign sample = {an, seg};

  always_comb begin
    same = (sample == s_q);
    if (!same)
      cnt_nxt = CW'(1);
    else if (cnt == CNT_MAX)
      cnt_nxt = cnt;
    else
      cnt_nxt = cnt + 1'b1;
    dwell = same && (cnt == CNT_TRIG);
  end

  always_comb begin
    low_cnt = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!an[i]) low_cnt = low_cnt + 1'b1;
    capture     = dwell && (low_cnt == LW'(1));
    multi       = dwell && (low_cnt > LW'(1));
    sel_mask    = capture ? ~an : '0;
    dec         = decode(seg);
    pattern_bad = capture && !dec[4];
    seen_upd    = seen | sel_mask;
    frame_done  = capture && (&seen_upd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '1;
      cnt         <= '0;
      seen        <= '0;
      bcd_out     <= '1;
      digit_valid <= '0;
      frame_stb   <= 1'b0;
      err_pattern <= 1'b0;
      err_anode   <= 1'b0;
    end else begin
      s_q       <= sample;
      cnt       <= cnt_nxt;
      frame_stb <= frame_done;
      seen      <= frame_done ? '0 : seen_upd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_mask[i]) begin
          digit_valid[i] <= dec[4];
          if (dec[4]) bcd_out[4*i +: 4] <= dec[3:0];
        end
      end
      // Setting takes priority over a simultaneous clear.
      err_pattern <= pattern_bad | (err_pattern & ~err_clr);
      err_anode   <= multi | (err_anode & ~err_clr);
    end
  end

endmodule
